// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, chooses step/branch/jump successors and offers the PC
// to fetch over valid/ready. Optional alignment trap enabled with macro PC_ALIGN_TRAP_EN.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pc_ready,
    input  logic                 branch_taken,
    input  logic [WIDTH-1:0]     branch_target,
    input  logic                 jump,
    input  logic [WIDTH-1:0]     jump_target,
    input  logic                 halt,
    input  logic                 resume,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     pc_plus_step,
    output logic                 pc_valid,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] fetch_count
`ifdef PC_ALIGN_TRAP_EN
    ,
    output logic                 trap
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
`ifdef PC_ALIGN_TRAP_EN
        ,
        ST_TRAP = 2'd3
`endif
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] target;
    logic             redirect;
    logic             fire;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign pc_plus_step = pc + WIDTH'(STEP);
    assign redirect     = jump | branch_taken;
    assign target       = jump ? jump_target : branch_target;
    assign fire         = pc_valid & pc_ready;

`ifdef PC_ALIGN_TRAP_EN
    logic misalign;
    assign misalign = redirect & (target[1:0] != 2'b00);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_BOOT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
`ifdef PC_ALIGN_TRAP_EN
                if (misalign) state_next = ST_TRAP;
                else
`endif
                if (halt) state_next = ST_HALT;
            end
            // Halt wins when both halt and resume are asserted.
            ST_HALT: if (resume && !halt) state_next = ST_RUN;
            default: state_next = state;
        endcase
    end

    always_comb begin
        pc_valid = (state == ST_RUN);
        halted   = (state == ST_HALT);
`ifdef PC_ALIGN_TRAP_EN
        trap     = (state == ST_TRAP);
`endif
    end

    // Redirects flush regardless of pc_ready; the halt edge still takes its successor.
    always_comb begin
        pc_next = pc;
        if (state == ST_RUN) begin
            if (redirect)  pc_next = target;
            else if (fire) pc_next = pc_plus_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_VECTOR;
            fetch_count <= '0;
        end else begin
            pc <= pc_next;
            if (fire) fetch_count <= sat_inc(fetch_count);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

    localparam int CW   = 8;
    localparam int CMAX = 255;
`ifdef PC_ALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2, M_TRAP = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ready, br, jmp, hlt, res;
    logic [31:0]   bt, jt;
    logic [31:0]   pc, pc_plus_step;
    logic          pc_valid, halted;
    logic [CW-1:0] fetch_count;
`ifdef PC_ALIGN_TRAP_EN
    logic          trap;
`endif

    int checks = 0;
    int errors = 0;

    int     m_mode;
    longint m_pc;
    int     m_cnt;

    pc_sequencer #(.WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .pc_ready(ready),
        .branch_taken(br), .branch_target(bt), .jump(jmp), .jump_target(jt),
        .halt(hlt), .resume(res), .pc(pc), .pc_plus_step(pc_plus_step),
        .pc_valid(pc_valid), .halted(halted), .fetch_count(fetch_count)
`ifdef PC_ALIGN_TRAP_EN
        , .trap(trap)
`endif
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode = M_BOOT;
        m_pc   = 0;
        m_cnt  = 0;
    endfunction

    // One clock edge of the sequencing rules, using the inputs currently driven.
    function automatic void model_step();
        longint tgt;
        bit     redir;
        redir = jmp || br;
        tgt   = jmp ? longint'(jt) : longint'(bt);
        case (m_mode)
            M_BOOT: m_mode = M_RUN;
            M_RUN: begin
                if (ready) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
                if (redir)      m_pc = tgt;
                else if (ready) m_pc = (m_pc + 4) % 64'h1_0000_0000;
                if (TRAP_EN && redir && (tgt % 4 != 0)) m_mode = M_TRAP;
                else if (hlt)                           m_mode = M_HALT;
            end
            M_HALT: if (res && !hlt) m_mode = M_RUN;
            default: ;
        endcase
    endfunction

    task automatic idle_inputs();
        ready = 0; br = 0; jmp = 0; hlt = 0; res = 0; bt = '0; jt = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        #1;
        model_reset();
        #1;
        rst_n = 1;
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (pc_plus_step !== 32'h4) begin errors++; $display("FAIL reset_pc_plus_step: got %h expected %h", pc_plus_step, 32'h4); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_pc_valid: got %b expected 0", pc_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (fetch_count !== 8'h0) begin errors++; $display("FAIL reset_fetch_count: got %0d expected 0", fetch_count); end
        rst_n = 1;
        ready = 1;
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL boot_pc_unchanged: got %h expected %h", pc, 32'h0); end
        checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL boot_to_run_valid: got %b expected 1", pc_valid); end
        checks++; if (fetch_count !== 8'h0) begin errors++; $display("FAIL boot_no_fire: got %0d expected 0", fetch_count); end
        ready = 0;
    endtask

    task automatic test_sequential();
        ready = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, 32'(i * 4)); end
            tick();
        end
        ready = 0;
        checks++; if (fetch_count !== 8'd4) begin errors++; $display("FAIL seq_count: got %0d expected 4", fetch_count); end
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL seq_pc_final: got %h expected %h", pc, 32'h10); end
    endtask

    task automatic test_branch_no_ready();
        jmp = 1; jt = 32'h10; ready = 0;
        tick();
        jmp = 0; br = 1; bt = 32'h100;
        tick();
        br = 0;
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL branch_pc: got %h expected %h", pc, 32'h100); end
        checks++; if (fetch_count !== 8'd4) begin errors++; $display("FAIL branch_count_held: got %0d expected 4", fetch_count); end
    endtask

    task automatic test_priority();
        int c0;
        c0 = m_cnt;
        jmp = 1; jt = 32'h200; br = 1; bt = 32'h300; ready = 1;
        tick();
        idle_inputs();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL jump_beats_branch: got %h expected %h", pc, 32'h200); end
        checks++; if (fetch_count !== 8'(c0 + 1)) begin errors++; $display("FAIL redirect_fire_counts: got %0d expected %0d", fetch_count, c0 + 1); end
    endtask

    task automatic test_wrap();
        int c0;
        jmp = 1; jt = 32'hFFFF_FFFC;
        tick();
        jmp = 0;
        checks++; if (pc_plus_step !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus_step: got %h expected %h", pc_plus_step, 32'h0); end
        c0 = m_cnt;
        ready = 1;
        tick();
        ready = 0;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (fetch_count !== 8'(c0 + 1)) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", fetch_count, c0 + 1); end
    endtask

    task automatic test_halt();
        int c0;
        jmp = 1; jt = 32'h40;
        tick();
        jmp = 0;
        c0 = m_cnt;
        hlt = 1; ready = 1;
        tick();
        hlt = 0;
        checks++; if (pc !== 32'h44) begin errors++; $display("FAIL halt_pc: got %h expected %h", pc, 32'h44); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted: got %b expected 1", halted); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL halt_pc_valid: got %b expected 0", pc_valid); end
        checks++; if (fetch_count !== 8'(c0 + 1)) begin errors++; $display("FAIL halt_edge_count: got %0d expected %0d", fetch_count, c0 + 1); end
        for (int i = 0; i < 3; i++) begin
            ready = 1'($urandom); jmp = 1'($urandom); jt = rand_target(); br = 1'($urandom); bt = rand_target();
            tick();
            checks++; if (pc !== 32'h44) begin errors++; $display("FAIL halt_hold_pc[%0d]: got %h expected %h", i, pc, 32'h44); end
            checks++; if (fetch_count !== 8'(c0 + 1)) begin errors++; $display("FAIL halt_hold_count[%0d]: got %0d expected %0d", i, fetch_count, c0 + 1); end
        end
        idle_inputs();
        hlt = 1; res = 1;
        tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_and_resume_stays: got %b expected 1", halted); end
        hlt = 0; res = 1;
        tick();
        res = 0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL resume_halted: got %b expected 0", halted); end
        checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL resume_pc_valid: got %b expected 1", pc_valid); end
        checks++; if (pc !== 32'h44) begin errors++; $display("FAIL resume_pc: got %h expected %h", pc, 32'h44); end
    endtask

    task automatic test_saturation();
        ready = 1;
        repeat (300) tick();
        ready = 0;
        checks++; if (fetch_count !== 8'hFF) begin errors++; $display("FAIL count_saturates: got %0d expected 255", fetch_count); end
        ready = 1;
        tick();
        ready = 0;
        checks++; if (fetch_count !== 8'hFF) begin errors++; $display("FAIL count_stays_saturated: got %0d expected 255", fetch_count); end
    endtask

    task automatic test_misaligned();
        jmp = 1; jt = 32'h102;
        tick();
        jmp = 0;
        checks++; if (pc !== 32'h102) begin errors++; $display("FAIL misaligned_pc: got %h expected %h", pc, 32'h102); end
`ifdef PC_ALIGN_TRAP_EN
        checks++; if (trap !== 1'b1) begin errors++; $display("FAIL trap_set: got %b expected 1", trap); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL trap_pc_valid: got %b expected 0", pc_valid); end
        for (int i = 0; i < 3; i++) begin
            ready = 1; res = 1; jmp = 1; jt = 32'h400;
            tick();
            checks++; if (pc !== 32'h102 || trap !== 1'b1) begin errors++; $display("FAIL trap_hold[%0d]: got pc=%h trap=%b expected pc=%h trap=1", i, pc, trap, 32'h102); end
        end
        idle_inputs();
`else
        checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL misaligned_still_valid: got %b expected 1", pc_valid); end
`endif
    endtask

    task automatic test_reset_mid();
        apply_reset();
        tick();
        ready = 1; jmp = 1; jt = 32'h80;
        tick();
        jmp = 0;
        tick();
        hlt = 1;
        tick();
        idle_inputs();
        checks++; if (halted !== 1'b1 || pc !== 32'h88) begin errors++; $display("FAIL pre_reset_state: got halted=%b pc=%h expected halted=1 pc=%h", halted, pc, 32'h88); end
        #2;
        rst_n = 0;
        #1;
        model_reset();
        checks++; if (pc !== 32'h0 || fetch_count !== 8'h0) begin errors++; $display("FAIL async_reset_pc_count: got pc=%h cnt=%0d expected pc=0 cnt=0", pc, fetch_count); end
        checks++; if (halted !== 1'b0 || pc_valid !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got halted=%b valid=%b expected 0 0", halted, pc_valid); end
        @(posedge clk);
        #1;
        rst_n = 1;
        tick();
        checks++; if (pc_valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL after_reset_run: got valid=%b pc=%h expected valid=1 pc=0", pc_valid, pc); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 50) apply_reset();
            ready = ($urandom_range(0, 3) != 0);
            jmp   = ($urandom_range(0, 7) == 0);
            jt    = rand_target();
            br    = ($urandom_range(0, 5) == 0);
            bt    = rand_target();
            hlt   = ($urandom_range(0, 15) == 0);
            res   = ($urandom_range(0, 3) == 0);
            tick();
            checks++; if (pc !== 32'(m_pc)) begin errors++; $display("FAIL rand_pc[%0d]: got %h expected %h", i, pc, 32'(m_pc)); end
            checks++; if (pc_plus_step !== 32'((m_pc + 4) % 64'h1_0000_0000)) begin errors++; $display("FAIL rand_pc_plus_step[%0d]: got %h expected %h", i, pc_plus_step, 32'(m_pc + 4)); end
            checks++; if (pc_valid !== (m_mode == M_RUN)) begin errors++; $display("FAIL rand_pc_valid[%0d]: got %b expected %b", i, pc_valid, m_mode == M_RUN); end
            checks++; if (halted !== (m_mode == M_HALT)) begin errors++; $display("FAIL rand_halted[%0d]: got %b expected %b", i, halted, m_mode == M_HALT); end
            checks++; if (fetch_count !== 8'(m_cnt)) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, fetch_count, m_cnt); end
`ifdef PC_ALIGN_TRAP_EN
            checks++; if (trap !== (m_mode == M_TRAP)) begin errors++; $display("FAIL rand_trap[%0d]: got %b expected %b", i, trap, m_mode == M_TRAP); end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        model_reset();
        test_reset();
        test_sequential();
        test_branch_no_ready();
        test_priority();
        test_wrap();
        test_halt();
        test_saturation();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
